// File: rtl/cl_word_adapter.sv
// cl_word_adapter: turns 32-bit CPU word reads/writes into 512-bit cache-line
// memory operations through a single-line, write-through line buffer.
module cl_word_adapter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CL_WIDTH   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cpu_op,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rd_valid,
  output logic                  cpu_tx_done,
  input  logic                  flush,
  output logic [1:0]            mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CL_WIDTH-1:0]   mem_wdata,
  input  logic [CL_WIDTH-1:0]   mem_rdata,
  input  logic                  mem_rd_valid,
  input  logic                  mem_tx_done
);

  localparam int unsigned WORDS    = CL_WIDTH / WORD_WIDTH;
  localparam int unsigned OFF_W    = $clog2(WORDS);
  localparam int unsigned BYTE_W   = $clog2(WORD_WIDTH / 8);
  localparam int unsigned LINE_LSB = OFF_W + BYTE_W;
  localparam int unsigned TAG_W    = ADDR_WIDTH - LINE_LSB;
  localparam int unsigned IDX_W    = $clog2(CL_WIDTH);
  localparam int unsigned WSH      = $clog2(WORD_WIDTH);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MERGE,
    S_WB,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [CL_WIDTH-1:0]   line_q, line_d;
  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic [OFF_W-1:0]      req_off_q, req_off_d;
  logic                  req_wr_q, req_wr_d;
  logic [WORD_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [WORD_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_rd_valid_q, cpu_rd_valid_d;
  logic                  cpu_tx_done_q, cpu_tx_done_d;
  logic [1:0]            mem_op_q, mem_op_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]      cpu_tag_c;
  logic [OFF_W-1:0]      cpu_off_c;
  logic                  hit_c;
  logic                  unused_byte_c;

  // Byte offset within the word is ignored; all accesses are full words.
  assign cpu_tag_c     = cpu_addr[ADDR_WIDTH-1:LINE_LSB];
  assign cpu_off_c     = cpu_addr[LINE_LSB-1:BYTE_W];
  assign hit_c         = valid_q && (tag_q == cpu_tag_c);
  assign unused_byte_c = ^cpu_addr[BYTE_W-1:0];

  function automatic logic [IDX_W-1:0] word_base(input logic [OFF_W-1:0] off);
    return IDX_W'(off) << WSH;
  endfunction

  // Next-state, line-buffer and registered-output logic.
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    line_d         = line_q;
    req_tag_d      = req_tag_q;
    req_off_d      = req_off_q;
    req_wr_d       = req_wr_q;
    req_wdata_d    = req_wdata_q;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_rd_valid_d = 1'b0;
    cpu_tx_done_d  = 1'b0;
    mem_op_d       = OP_NONE;
    mem_addr_d     = mem_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = 1'b0;
        end else if (cpu_op == OP_READ || cpu_op == OP_WRITE) begin
          req_tag_d   = cpu_tag_c;
          req_off_d   = cpu_off_c;
          req_wr_d    = (cpu_op == OP_WRITE);
          req_wdata_d = cpu_wdata;
          if (hit_c) begin
            state_d = (cpu_op == OP_WRITE) ? S_MERGE : S_RESP;
          end else begin
            // Buffer contents are about to be overwritten by the fill.
            valid_d = 1'b0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (mem_rd_valid) begin
          line_d = mem_rdata;
        end
        if (mem_tx_done) begin
          tag_d   = req_tag_q;
          valid_d = 1'b1;
          state_d = req_wr_q ? S_MERGE : S_RESP;
        end
      end
      S_MERGE: begin
        line_d[word_base(req_off_q) +: WORD_WIDTH] = req_wdata_q;
        state_d = S_WB;
      end
      S_WB: begin
        if (mem_tx_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered against the state being entered so that they
    // are valid for exactly the cycles spent in that state.
    unique case (state_d)
      S_FILL: begin
        mem_op_d   = OP_READ;
        mem_addr_d = {req_tag_d, LINE_LSB'(0)};
      end
      S_WB: begin
        mem_op_d   = OP_WRITE;
        mem_addr_d = {req_tag_d, LINE_LSB'(0)};
      end
      S_RESP: begin
        cpu_tx_done_d = 1'b1;
        if (!req_wr_d) begin
          cpu_rd_valid_d = 1'b1;
          cpu_rdata_d    = line_d[word_base(req_off_d) +: WORD_WIDTH];
        end
      end
      default: begin
        mem_op_d = OP_NONE;
      end
    endcase
  end

  // State and output registers; reset aborts any outstanding operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      valid_q        <= 1'b0;
      tag_q          <= '0;
      line_q         <= '0;
      req_tag_q      <= '0;
      req_off_q      <= '0;
      req_wr_q       <= 1'b0;
      req_wdata_q    <= '0;
      cpu_rdata_q    <= '0;
      cpu_rd_valid_q <= 1'b0;
      cpu_tx_done_q  <= 1'b0;
      mem_op_q       <= OP_NONE;
      mem_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      req_tag_q      <= req_tag_d;
      req_off_q      <= req_off_d;
      req_wr_q       <= req_wr_d;
      req_wdata_q    <= req_wdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rd_valid_q <= cpu_rd_valid_d;
      cpu_tx_done_q  <= cpu_tx_done_d;
      mem_op_q       <= mem_op_d;
      mem_addr_q     <= mem_addr_d;
    end
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign cpu_tx_done  = cpu_tx_done_q;
  assign mem_op       = mem_op_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = line_q;

endmodule

// File: tb/tb_cl_word_adapter.sv
// tb_cl_word_adapter: random and directed word traffic checked against a
// flat word-addressed memory model plus a one-line hit/miss model.
module tb_cl_word_adapter;

  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned CW = 512;
  localparam logic [1:0]  OP_R = 2'b01;
  localparam logic [1:0]  OP_W = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cpu_op;
  logic [AW-1:0] cpu_addr;
  logic [WW-1:0] cpu_wdata;
  logic [WW-1:0] cpu_rdata;
  logic          cpu_rd_valid;
  logic          cpu_tx_done;
  logic          flush;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;
  logic          mem_rd_valid;
  logic          mem_tx_done;

  cl_word_adapter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CL_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_op       (cpu_op),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_tx_done  (cpu_tx_done),
    .flush        (flush),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rd_valid (mem_rd_valid),
    .mem_tx_done  (mem_tx_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: backing memory, and which line the adapter should hold.
  logic [31:0] mem_q [logic [29:0]];
  bit          m_valid = 1'b0;
  logic [25:0] m_tag   = '0;
  bit          pend    = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [29:0] k;
    k = a[31:2];
    if (mem_q.exists(k)) return mem_q[k];
    return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
  endfunction

  // Expected line image: memory contents with optionally one word replaced.
  function automatic logic [CW-1:0] line_img(input logic [31:0] a, input bit repl, input logic [31:0] wd);
    logic [CW-1:0] l;
    logic [31:0]   wa;
    l = '0;
    for (int i = 15; i >= 0; i--) begin
      wa = {a[31:6], 6'(i * 4)};
      l  = {l[CW-33:0], (repl && wa[5:2] == a[5:2]) ? wd : mem_word(wa)};
    end
    return l;
  endfunction

  function automatic logic [CW-1:0] rand_line();
    logic [CW-1:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l = {l[CW-33:0], 32'($urandom())};
    return l;
  endfunction

  // Previous response must have been a single-cycle pulse with held read data.
  task automatic post_chk();
    if (pend) begin
      check_val("done_pulse", 512'(cpu_tx_done), 512'(0));
      check_val("rdv_pulse", 512'(cpu_rd_valid), 512'(0));
      check_val("rdata_hold", 512'(cpu_rdata), 512'(last_rdata));
      pend = 1'b0;
    end
  endtask

  task automatic idle_flush();
    @(posedge clk); #1;
    post_chk();
    cpu_op = 2'b00;
    flush  = 1'b1;
    m_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // One CPU transaction; the loop also plays the memory side of the arbiter.
  // rdv_mode: 0 random rd_valid position, 1 coincident with tx_done, 2 three cycles before.
  task automatic do_op(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit with_flush, input int rdv_mode);
    logic [1:0]  op0, op1, exp_op, cur_op;
    logic [31:0] line_a;
    int          n_ops, k, s, sum_l, prev_end, lat, rdv_at, cnt, first_start;
    bit          hit, busy, done;
    op0 = 2'b00; op1 = 2'b00; cur_op = 2'b00;
    n_ops = 0; k = 0; s = 0; sum_l = 0; prev_end = -1; lat = 0; rdv_at = 0; cnt = 0;
    busy = 1'b0; done = 1'b0;
    line_a = {addr[31:6], 6'b0};
    @(posedge clk); #1;
    post_chk();
    cpu_op    = write ? OP_W : OP_R;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    flush     = with_flush;
    if (with_flush) m_valid = 1'b0;
    hit = m_valid && (m_tag == addr[31:6]);
    if (!hit) begin op0 = OP_R; n_ops = 1; end
    if (write) begin
      if (n_ops == 0) op0 = OP_W; else op1 = OP_W;
      n_ops++;
    end
    first_start = (write && hit) ? 2 : 1 + int'(with_flush);
    while (!done && s < 80) begin
      @(posedge clk); #1;
      s++;
      flush = 1'b0;
      if (!busy && mem_op != 2'b00) begin
        exp_op = (k < n_ops) ? ((k == 0) ? op0 : op1) : 2'b00;
        check_val("mem_op", 512'(mem_op), 512'(exp_op));
        check_val("mem_addr", 512'(mem_addr), 512'(line_a));
        check_val("mem_start", 512'(s), 512'((prev_end < 0) ? first_start : prev_end + 2));
        if (mem_op == OP_W) check_val("mem_wdata", mem_wdata, line_img(addr, 1'b1, wdata));
        k++;
        busy   = 1'b1;
        cur_op = mem_op;
        cnt    = 0;
        lat    = $urandom_range(0, 4);
        case (rdv_mode)
          1: rdv_at = lat;
          2: begin lat = 3 + $urandom_range(0, 2); rdv_at = lat - 3; end
          default: rdv_at = $urandom_range(0, lat);
        endcase
      end else if (busy) begin
        check_val("mem_op_hold", 512'(mem_op), 512'(cur_op));
      end
      mem_rd_valid = 1'b0;
      mem_tx_done  = 1'b0;
      mem_rdata    = rand_line();
      if (busy) begin
        if (cur_op == OP_R && cnt == rdv_at) begin
          mem_rd_valid = 1'b1;
          mem_rdata    = line_img(addr, 1'b0, 32'h0);
        end
        if (cnt == lat) begin
          mem_tx_done = 1'b1;
          busy        = 1'b0;
          prev_end    = s;
          sum_l      += lat + 1;
          if (cur_op == OP_W) mem_q[addr[31:2]] = wdata;
        end
        cnt++;
      end
      if (cpu_tx_done) done = 1'b1;
    end
    if (!done) begin
      check_val("timeout", 512'(0), 512'(1));
      mem_rd_valid = 1'b0;
      mem_tx_done  = 1'b0;
    end else begin
      check_val("latency", 512'(s + 1), 512'(2 + int'(with_flush) + sum_l + int'(write)));
      check_val("ops_seen", 512'(k), 512'(n_ops));
      check_val("rd_valid", 512'(cpu_rd_valid), 512'(!write));
      if (!write) begin
        check_val("rdata", 512'(cpu_rdata), 512'(mem_word(addr)));
        last_rdata = mem_word(addr);
      end
      m_valid = 1'b1;
      m_tag   = addr[31:6];
      pend    = 1'b1;
    end
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_mem_op"}, 512'(mem_op), 512'(0));
    check_val({tag, "_tx_done"}, 512'(cpu_tx_done), 512'(0));
    check_val({tag, "_rd_valid"}, 512'(cpu_rd_valid), 512'(0));
    check_val({tag, "_rdata"}, 512'(cpu_rdata), 512'(0));
    check_val({tag, "_mem_addr"}, 512'(mem_addr), 512'(0));
    check_val({tag, "_mem_wdata"}, mem_wdata, 512'(0));
  endtask

  initial begin
    logic [31:0] bases [4];
    logic [31:0] a;
    bit          got_wb;
    bases[0] = 32'h0000_1000; bases[1] = 32'h0000_2000;
    bases[2] = 32'h0001_1000; bases[3] = 32'hFFFF_FFC0;
    for (int i = 0; i < 16; i++) mem_q[30'(32'h400 + i)] = 32'hA000_0000 + 32'(i);

    rst_n = 1'b0; cpu_op = OP_R; cpu_addr = 32'h0000_1004; cpu_wdata = '0; flush = 1'b0;
    mem_rdata = '0; mem_rd_valid = 1'b0; mem_tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    cpu_op = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 32'h0000_1004, 32'h0, 1'b0, 0);
    do_op(1'b0, 32'h0000_103C, 32'h0, 1'b0, 0);
    do_op(1'b0, 32'h0000_1000, 32'h0, 1'b0, 0);
    do_op(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 0);
    do_op(1'b0, 32'h0000_1008, 32'h0, 1'b0, 0);
    do_op(1'b0, 32'h0000_1000, 32'h0, 1'b1, 0);
    do_op(1'b1, 32'h0000_2000, 32'h1357_9BDF, 1'b0, 0);
    do_op(1'b0, 32'h0000_4000, 32'h0, 1'b0, 2);
    do_op(1'b0, 32'h0000_5004, 32'h0, 1'b0, 1);

    // Write hit on the cached 0x5000 line, reset once the write-back is on the bus.
    @(posedge clk); #1;
    post_chk();
    cpu_op = OP_W; cpu_addr = 32'h0000_5008; cpu_wdata = 32'h1234_5678;
    got_wb = 1'b0;
    for (int i = 0; i < 10 && !got_wb; i++) begin
      @(posedge clk); #1;
      if (mem_op == OP_W) got_wb = 1'b1;
    end
    check_val("wb_reached", 512'(got_wb), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midwb");
    cpu_op = 2'b00;
    m_valid = 1'b0; last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'h0000_5008, 32'h0, 1'b0, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) idle_flush();
      a = bases[$urandom_range(0, 3)] | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), a, 32'($urandom()), $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 2)));
    end
    @(posedge clk); #1;
    post_chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
